// File: rtl/kbd_pkg.sv
// Shared types and default constants for the console keyboard scan sequencer.
package kbd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam int DEF_DEPTH         = 8;
  localparam int DEF_STROBE_CYCLES = 3;
  localparam int DEF_WINDOW        = 8;

  localparam logic [7:0] SCAN_RELEASE = 8'hF0;

endpackage

// File: rtl/kbd_fifo.sv
// Synchronous scancode FIFO; dout is the live head entry (no output register).
module kbd_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  // Fullness is judged on the pre-pop count, so a push into a full FIFO drops
  // even when a pop happens in the same cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/kbd_scan_sequencer.sv
// Buffers PS/2 scancodes, issues them to the ASCII converter with a timed strobe,
// and presents converted characters to the CPU with a KL8-style flag/clear handshake.
module kbd_scan_sequencer
  import kbd_pkg::*;
#(
  parameter int DEPTH         = DEF_DEPTH,
  parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
  parameter int WINDOW        = DEF_WINDOW
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [7:0]             scan_code,
  input  logic                   scan_valid,
  output logic [7:0]             conv_scancode,
  output logic                   conv_strobe,
  input  logic [7:0]             conv_ascii,
  input  logic                   conv_ready,
  output logic [7:0]             kbd_data,
  output logic                   kbd_flag,
  input  logic                   kbd_clear,
  output logic                   overrun,
  output logic                   dropped,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy
);

  localparam int CNT_MAX = (STROBE_CYCLES > WINDOW) ? STROBE_CYCLES : WINDOW;
  localparam int CNT_W   = $clog2(CNT_MAX);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]      conv_scancode_q, conv_scancode_d;
  logic            conv_strobe_q, conv_strobe_d;
  logic            busy_q, busy_d;
  logic            rdy_prev_q, rdy_prev_d;
  logic            got_q, got_d;
  logic [7:0]      cap_q, cap_d;
  logic            cap_vld_q, cap_vld_d;
  logic [7:0]      kbd_data_q, kbd_data_d;
  logic            kbd_flag_q, kbd_flag_d;
  logic            overrun_q, overrun_d;
  logic            dropped_q, dropped_d;

  logic            fifo_pop, fifo_full, fifo_empty;
  logic [7:0]      fifo_dout;
  logic            capture;

  kbd_fifo #(.DEPTH(DEPTH), .DATA_W(8)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (scan_valid),
    .pop   (fifo_pop),
    .din   (scan_code),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Only the first conv_ready rising edge per issued byte is taken.
  assign capture = conv_ready && !rdy_prev_q && (state_q != IDLE) && !got_q;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    conv_scancode_d = conv_scancode_q;
    conv_strobe_d   = conv_strobe_q;
    busy_d          = busy_q;
    got_d           = got_q | capture;
    fifo_pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop        = 1'b1;
          state_d         = ISSUE;
          cnt_d           = '0;
          conv_scancode_d = fifo_dout;
          conv_strobe_d   = 1'b1;
          busy_d          = 1'b1;
          got_d           = 1'b0;
        end
      end
      ISSUE: begin
        if (cnt_q == CNT_W'(STROBE_CYCLES - 1)) begin
          state_d       = WAIT;
          cnt_d         = '0;
          conv_strobe_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(WINDOW - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d       = IDLE;
        conv_strobe_d = 1'b0;
        busy_d        = 1'b0;
      end
    endcase
  end

  // A delivery that coincides with kbd_clear replaces the old character cleanly.
  always_comb begin
    rdy_prev_d = conv_ready;
    cap_d      = capture ? conv_ascii : cap_q;
    cap_vld_d  = capture;
    kbd_data_d = kbd_data_q;
    kbd_flag_d = kbd_flag_q;
    overrun_d  = overrun_q;
    dropped_d  = dropped_q | (scan_valid && fifo_full);
    if (cap_vld_q) begin
      if (!kbd_flag_q || kbd_clear) begin
        kbd_data_d = cap_q;
        kbd_flag_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (kbd_clear) begin
      kbd_flag_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      conv_scancode_q <= '0;
      conv_strobe_q   <= 1'b0;
      busy_q          <= 1'b0;
      rdy_prev_q      <= 1'b0;
      got_q           <= 1'b0;
      cap_vld_q       <= 1'b0;
      kbd_data_q      <= '0;
      kbd_flag_q      <= 1'b0;
      overrun_q       <= 1'b0;
      dropped_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      conv_scancode_q <= conv_scancode_d;
      conv_strobe_q   <= conv_strobe_d;
      busy_q          <= busy_d;
      rdy_prev_q      <= rdy_prev_d;
      got_q           <= got_d;
      cap_vld_q       <= cap_vld_d;
      kbd_data_q      <= kbd_data_d;
      kbd_flag_q      <= kbd_flag_d;
      overrun_q       <= overrun_d;
      dropped_q       <= dropped_d;
    end
  end

  always_ff @(posedge clock) begin
    cap_q <= cap_d;
  end

  assign conv_scancode = conv_scancode_q;
  assign conv_strobe   = conv_strobe_q;
  assign busy          = busy_q;
  assign kbd_data      = kbd_data_q;
  assign kbd_flag      = kbd_flag_q;
  assign overrun       = overrun_q;
  assign dropped       = dropped_q;

endmodule
